// File: rtl/bram_stream_reader.sv
// Small synchronous FIFO with head-of-queue output and synchronous clear.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module bram_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic [WIDTH-1:0]             head_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_vld && !pop) begin
                count <= count + 1'b1;
            end else if (!push_vld && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];
endmodule

// Burst reader: turns (addr, len) requests into BRAM reads and a valid/ready line stream.
// Latency: request edge E0 -> read in the next cycle -> out_valid after edge E2.
// Backpressure: reads are throttled so FIFO entries plus the in-flight read never exceed 2.
module bram_stream_reader #(
    parameter int LINE_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AW-1:0]         req_addr,
    input  logic [AW:0]           req_len,
    input  logic                  flush,
    output logic                  bram_ren,
    output logic [AW-1:0]         bram_raddr,
    input  logic [LINE_WIDTH-1:0] bram_rline,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LINE_WIDTH-1:0] out_line,
    output logic                  out_last,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   issue_ptr;
    logic [AW:0]     remaining_issue;
    logic            inflight;
    logic            inflight_last;
    logic [1:0]      fifo_count;
    logic            fifo_empty;
    logic            pop;
    logic            accept;
    logic            last_issue;
    logic [2:0]      occupancy;
    logic [LINE_WIDTH:0] head_dat;

    assign pop        = out_valid & out_ready;
    assign occupancy  = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign last_issue = (remaining_issue == {{AW{1'b0}}, 1'b1});
    assign accept     = (state == IDLE) && req_valid && !flush && (req_len != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bram_ren  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bram_ren = (remaining_issue != '0) && (occupancy < 3'd2);
                if (bram_ren && last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            bram_ren  = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_ptr       <= '0;
            remaining_issue <= '0;
            inflight        <= 1'b0;
            inflight_last   <= 1'b0;
        end else if (flush) begin
            issue_ptr       <= '0;
            remaining_issue <= '0;
            inflight        <= 1'b0;
            inflight_last   <= 1'b0;
        end else begin
            if (accept) begin
                issue_ptr       <= req_addr;
                remaining_issue <= req_len;
            end else if (bram_ren) begin
                issue_ptr       <= issue_ptr + 1'b1;
                remaining_issue <= remaining_issue - 1'b1;
            end
            inflight      <= bram_ren;
            inflight_last <= bram_ren && last_issue;
        end
    end

    // A read landing on the flush edge is dropped: the clear wins inside the FIFO.
    bram_stream_fifo #(
        .WIDTH (LINE_WIDTH + 1),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push_vld (inflight && !flush),
        .push_dat ({inflight_last, bram_rline}),
        .pop      (pop),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .head_dat (head_dat)
    );

    assign bram_raddr = issue_ptr;
    assign out_valid  = !fifo_empty;
    assign out_line   = head_dat[LINE_WIDTH-1:0];
    assign out_last   = head_dat[LINE_WIDTH];
    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader with a behavioural 1-cycle-latency BRAM.
module tb_bram_stream_reader;
    localparam int LW = 32;
    localparam int DP = 128;
    localparam int AW = 7;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [AW:0]   req_len;
    logic          flush;
    logic          bram_ren;
    logic [AW-1:0] bram_raddr;
    logic [LW-1:0] bram_rline;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_line;
    logic          out_last;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [LW-1:0] mem [DP];
    logic [LW:0]   exp_q [$];
    logic [AW-1:0] addr_q [$];

    int   pops        = 0;
    int   outstanding = 0;
    int   max_out     = 0;
    bit   prev_stall  = 0;
    logic [LW-1:0] prev_line;
    logic          prev_last;
    bit   pop_s;
    logic [LW:0]   e_line;
    logic [AW-1:0] e_addr;

    bram_stream_reader #(.LINE_WIDTH(LW), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .flush      (flush),
        .bram_ren   (bram_ren),
        .bram_raddr (bram_raddr),
        .bram_rline (bram_rline),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_line   (out_line),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_ren) bram_rline <= mem[bram_raddr];
    end

    // Scoreboard monitor: samples on the falling edge, i.e. the handshakes of the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_line !== prev_line || out_last !== prev_last) begin
                    bad++;
                    $display("FAIL hold_stable: valid=%b line=%h last=%b, required valid=1 line=%h last=%b",
                             out_valid, out_line, out_last, prev_line, prev_last);
                end
            end
            if (bram_ren === 1'b1) begin
                total++;
                if (addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL raddr_unexpected: read issued at raddr=%0d, required no read", bram_raddr);
                end else begin
                    e_addr = addr_q.pop_front();
                    if (bram_raddr !== e_addr) begin
                        bad++;
                        $display("FAIL raddr: got %0d, required %0d", bram_raddr, e_addr);
                    end
                end
            end
            pop_s = (out_valid === 1'b1) && (out_ready === 1'b1);
            if (pop_s) begin
                total++;
                pops++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL line_unexpected: got line=%h last=%b, required no output", out_line, out_last);
                end else begin
                    e_line = exp_q.pop_front();
                    if ({out_last, out_line} !== e_line) begin
                        bad++;
                        $display("FAIL line: got last=%b line=%h, required last=%b line=%h",
                                 out_last, out_line, e_line[LW], e_line[LW-1:0]);
                    end
                end
            end
            if (bram_ren === 1'b1) outstanding++;
            if (pop_s) outstanding--;
            if (outstanding > max_out) max_out = outstanding;
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1) && (flush !== 1'b1);
            prev_line  = out_line;
            prev_last  = out_last;
        end
    end

    task automatic do_req(input logic [AW-1:0] a, input logic [AW:0] l);
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        for (int i = 0; i < int'(l); i++) begin
            logic [AW-1:0] ad;
            ad = a + i[AW-1:0];
            addr_q.push_back(ad);
            exp_q.push_back({(i == int'(l) - 1), mem[ad]});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (busy === 1'b0) && (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1)  begin bad++; $display("FAIL rst_req_ready: got %b, required 1", req_ready); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        total++; if (bram_ren !== 1'b0)   begin bad++; $display("FAIL rst_ren: got %b, required 0", bram_ren); end
        total++; if (bram_raddr !== '0)   begin bad++; $display("FAIL rst_raddr: got %0d, required 0", bram_raddr); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        total++; if (out_line !== '0)     begin bad++; $display("FAIL rst_out_line: got %h, required 0", out_line); end
        total++; if (out_last !== 1'b0)   begin bad++; $display("FAIL rst_out_last: got %b, required 0", out_last); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [6:1] v;
        logic [6:1] b;
        bit ok;
        out_ready = 1'b1;
        do_req(7'd5, 8'd4);
        total++;
        if (bram_ren !== 1'b1 || bram_raddr !== 7'd5) begin
            bad++; $display("FAIL basic_first_issue: ren=%b raddr=%0d, required ren=1 raddr=5", bram_ren, bram_raddr);
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            v[k] = out_valid;
            b[k] = busy;
        end
        total++; if (v !== 6'b011110) begin bad++; $display("FAIL basic_valid_timing: got %b, required 011110", v); end
        total++; if (b !== 6'b011111) begin bad++; $display("FAIL basic_busy_timing: got %b, required 011111", b); end
        wait_idle(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_done: pending=%0d busy=%b, required 0/0", exp_q.size(), busy); end
    endtask

    task automatic test_wrap();
        bit ok;
        out_ready = 1'b1;
        do_req(7'd126, 8'd4);
        wait_idle(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_done: pending=%0d busy=%b, required 0/0", exp_q.size(), busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int n = 0;
        max_out = 0;
        out_ready = 1'b1;
        do_req(7'd40, 8'd8);
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
            out_ready = pat[n % 4];
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        wait_idle(5, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_done: pending=%0d busy=%b, required 0/0", exp_q.size(), busy); end
        total++; if (max_out > 2) begin bad++; $display("FAIL bp_occupancy: got %0d, required <=2", max_out); end
    endtask

    task automatic test_zero_busy();
        bit ok;
        bit seen = 0;
        out_ready = 1'b1;
        do_req(7'd10, 8'd0);
        for (int k = 0; k < 4; k++) begin
            if (busy !== 1'b0 || out_valid !== 1'b0 || bram_ren !== 1'b0) seen = 1;
            @(posedge clk); #1;
        end
        total++; if (seen) begin bad++; $display("FAIL zero_len: activity seen=1, required 0"); end
        do_req(7'd20, 8'd3);
        req_valid = 1'b1;
        req_addr  = 7'd90;
        req_len   = 8'd5;
        total++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL busy_ready: req_ready=%b busy=%b, required 0/1", req_ready, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL busy_req_done: pending=%0d busy=%b, required 0/0", exp_q.size(), busy); end
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || out_valid !== 1'b0) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL busy_req_ignored: activity seen=1, required 0"); end
    endtask

    task automatic test_flush();
        bit ok;
        bit seen = 0;
        int n = 0;
        int p0;
        out_ready = 1'b1;
        pops = 0;
        do_req(7'd0, 8'd16);
        while (pops < 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (pops != 3) begin bad++; $display("FAIL flush_setup: pops=%0d, required 3", pops); end
        flush     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        addr_q.delete();
        outstanding = 0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL flush_idle: busy=%b valid=%b req_ready=%b, required 0/0/1", busy, out_valid, req_ready);
        end
        for (int k = 0; k < 4; k++) begin
            if (out_valid !== 1'b0 || bram_ren !== 1'b0) seen = 1;
            @(posedge clk); #1;
        end
        total++; if (seen) begin bad++; $display("FAIL flush_stale: activity seen=1, required 0"); end
        out_ready = 1'b1;
        p0 = pops;
        do_req(7'd0, 8'd2);
        wait_idle(30, ok);
        total++; if (!ok || pops - p0 != 2) begin
            bad++; $display("FAIL flush_new_burst: lines=%0d pending=%0d, required 2/0", pops - p0, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int n = 0;
        int p0;
        out_ready = 1'b1;
        p0 = pops;
        do_req(7'd60, 8'd10);
        while (pops - p0 < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        #2 rst = 1'b0;
        #1;
        total++; if (bram_ren !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 ||
                     out_line !== '0 || out_last !== 1'b0 || bram_raddr !== '0) begin
            bad++; $display("FAIL arst_outputs: ren=%b valid=%b busy=%b rdy=%b line=%h last=%b raddr=%0d, required 0/0/0/1/0/0/0",
                            bram_ren, out_valid, busy, req_ready, out_line, out_last, bram_raddr);
        end
        exp_q.delete();
        addr_q.delete();
        outstanding = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL arst_release: req_ready=%b valid=%b, required 1/0", req_ready, out_valid);
        end
        do_req(7'd100, 8'd3);
        wait_idle(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL arst_new_burst: pending=%0d busy=%b, required 0/0", exp_q.size(), busy); end
    endtask

    initial begin
        for (int i = 0; i < DP; i++) mem[i] = $urandom;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_busy();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
